// File: rtl/commit_track_grid.sv
// commit_track_grid: in-order commit tracker for an R x C TPU array.
// Each issued instruction is stored with the set of TPUs that must report
// termination. Reports may arrive in any order. Issue numbers retire to the
// MPU strictly in issue order, at most one per cycle.
// Optional build macro: COMMIT_TIMEOUT_EN (head-entry watchdog driving O_Timeout).
//
// state | meaning
// ------+------------------------------------------------------------
// empty | count == 0, no live entries, nothing can retire
// busy  | 0 < count < DEPTH, allocations accepted, head retires when done
// full  | count == DEPTH, I_Req is dropped and flagged as overflow
module commit_track_grid #(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_CLMS    = 2,
  parameter int DEPTH       = 8,
  parameter int ISSUE_W     = 8,
  parameter int TIMEOUT_CYC = 1024,
  localparam int NUM_TPU    = NUM_ROWS * NUM_CLMS,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Req,
  input  logic [ISSUE_W-1:0]         I_Issue_No,
  input  logic [NUM_TPU-1:0]         I_En_TPU,
  input  logic [NUM_TPU-1:0]         I_Commit_Req,
  input  logic [NUM_TPU*ISSUE_W-1:0] I_Commit_No,
  output logic                       O_Commit_Req,
  output logic [ISSUE_W-1:0]         O_Commit_No,
  output logic                       O_Full,
  output logic                       O_Empty,
  output logic [CNT_W-1:0]           O_Count,
  output logic                       O_Err_Ovf,
  output logic                       O_Err_Stray,
  output logic                       O_Timeout
);

  logic [DEPTH-1:0]                valid;
  logic [DEPTH-1:0][ISSUE_W-1:0]   ent_no;
  logic [DEPTH-1:0][NUM_TPU-1:0]   pend;
  logic [PTR_W-1:0]                wptr;
  logic [PTR_W-1:0]                rptr;
  logic [CNT_W-1:0]                count;

  logic                            alloc;
  logic                            retire;
  logic [DEPTH-1:0][NUM_TPU-1:0]   clr;
  logic [NUM_TPU-1:0]              alloc_clr;
  logic [NUM_TPU-1:0]              hit;
  logic [NUM_TPU-1:0]              head_pend_nxt;

  // Flags come from the registered count, so a same-cycle retire never frees a slot early.
  assign O_Full  = (count == CNT_W'(DEPTH));
  assign O_Empty = (count == '0);
  assign O_Count = count;
  assign alloc   = I_Req && !O_Full;

  // Match every TPU report against all live entries and the entry being allocated this cycle.
  always_comb begin
    clr       = '0;
    alloc_clr = '0;
    hit       = '0;
    for (int t = 0; t < NUM_TPU; t++) begin
      if (I_Commit_Req[t]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (valid[e] && (ent_no[e] == I_Commit_No[t*ISSUE_W +: ISSUE_W])) begin
            clr[e][t] = 1'b1;
            if (pend[e][t]) hit[t] = 1'b1;
          end
        end
        if (alloc && (I_Issue_No == I_Commit_No[t*ISSUE_W +: ISSUE_W])) begin
          alloc_clr[t] = 1'b1;
          if (I_En_TPU[t]) hit[t] = 1'b1;
        end
      end
    end
  end

  // The head retires at the same edge that clears its last pending bit.
  assign head_pend_nxt = pend[rptr] & ~clr[rptr];
  assign retire        = valid[rptr] && (head_pend_nxt == '0);

  // Entry storage, pointers, occupancy, retire pulse and sticky error flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid        <= '0;
      ent_no       <= '0;
      pend         <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      O_Commit_Req <= 1'b0;
      O_Commit_No  <= '0;
      O_Err_Ovf    <= 1'b0;
      O_Err_Stray  <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        pend[e] <= pend[e] & ~clr[e];
      end
      if (retire) begin
        valid[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
        O_Commit_No <= ent_no[rptr];
      end
      // The write slot is always free when not full, so it never collides with the head.
      if (alloc) begin
        valid[wptr]  <= 1'b1;
        ent_no[wptr] <= I_Issue_No;
        pend[wptr]   <= I_En_TPU & ~alloc_clr;
        wptr         <= wptr + 1'b1;
      end
      O_Commit_Req <= retire;
      case ({alloc, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (I_Req && O_Full) O_Err_Ovf <= 1'b1;
      if ((I_Commit_Req & ~hit) != '0) O_Err_Stray <= 1'b1;
    end
  end

`ifdef COMMIT_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);
  logic [AGE_W-1:0] head_age;

  // Only the head can block retirement, so a single age counter follows it; it saturates at the limit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_age  <= '0;
      O_Timeout <= 1'b0;
    end else begin
      if (retire) begin
        head_age <= '0;
      end else if (valid[rptr] && (pend[rptr] != '0) && (head_age != AGE_W'(TIMEOUT_CYC))) begin
        head_age <= head_age + 1'b1;
      end
      if (head_age == AGE_W'(TIMEOUT_CYC)) O_Timeout <= 1'b1;
    end
  end
`else
  assign O_Timeout = 1'b0;
`endif

endmodule
